// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//
// Hardwired control-step sequencer for one register-register ALU instruction.
// Fetch runs T0..T2 (with a memory wait in T1); execute runs T3..T5, plus T6
// for the MUL/DIV opcodes, which write the 64-bit result back as LO then HI.
//
// Ports
//   clock      : system clock, all state changes on the rising edge
//   clear      : asynchronous active-high reset, forces IDLE immediately
//   start      : run one instruction; looked at only while in IDLE
//   mem_ready  : memory read data valid; looked at only while in T1
//   ir         : current instruction register contents
//   Rin/Rout   : one-hot register load / bus-drive enables
//   PCout..HIin: single-bit datapath strobes
//   opcode     : ALU operation select, nonzero only in T4
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse in the cycle after the last execute step
//   state_dbg  : current FSM state (IDLE=0, T0=1 .. T6=7)
//
// Handshake: start is a request sampled on a rising edge while IDLE; it is
// dropped (not queued) while busy. done is the matching completion pulse
// and coincides with IDLE, so a start held during done chains the next
// instruction with no gap cycle.
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int              NUM_REGS = 16,
    parameter int              IR_W     = 32,
    parameter int              OP_W     = 5,
    parameter int              RIDX_W   = 4,
    parameter logic [OP_W-1:0] MUL_OP   = 5'b01111,
    parameter logic [OP_W-1:0] DIV_OP   = 5'b10000
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic                mem_ready,
    input  logic [IR_W-1:0]     ir,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic                PCout,
    output logic                PCin,
    output logic                incPC,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                read,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                ZLowOut,
    output logic                ZHighOut,
    output logic                LOin,
    output logic                HIin,
    output logic [OP_W-1:0]     opcode,
    output logic                busy,
    output logic                done,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T0   = 3'd1,
        T1   = 3'd2,
        T2   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5,
        T5   = 3'd6,
        T6   = 3'd7
    } state_t;

    localparam int RA_MSB = IR_W - OP_W - 1;

    state_t state;
    state_t state_next;

    logic [OP_W-1:0]   op;
    logic [RIDX_W-1:0] ra;
    logic [RIDX_W-1:0] rb;
    logic [RIDX_W-1:0] rc;
    logic              hilo;
    logic              unused_ir_bits;

    assign op   = ir[IR_W-1 -: OP_W];
    assign ra   = ir[RA_MSB -: RIDX_W];
    assign rb   = ir[RA_MSB - RIDX_W -: RIDX_W];
    assign rc   = ir[RA_MSB - 2*RIDX_W -: RIDX_W];
    assign hilo = (op == MUL_OP) || (op == DIV_OP);

    // Bits below the rc field carry no meaning for this sequencer.
    assign unused_ir_bits = ^ir;

    // Index to one-hot; an index at or above NUM_REGS selects nothing.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [RIDX_W-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(idx) == i) v[i] = 1'b1;
        end
        return v;
    endfunction

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= ((state == T5) && !hilo) || (state == T6);
        end
    end

    always_comb begin
        state_next = state;
        Rin        = '0;
        Rout       = '0;
        PCout      = 1'b0;
        PCin       = 1'b0;
        incPC      = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        read       = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zin        = 1'b0;
        ZLowOut    = 1'b0;
        ZHighOut   = 1'b0;
        LOin       = 1'b0;
        HIin       = 1'b0;
        opcode     = '0;
        case (state)
            IDLE: begin
                if (start) state_next = T0;
            end
            T0: begin
                PCout      = 1'b1;
                MARin      = 1'b1;
                incPC      = 1'b1;
                Zin        = 1'b1;
                state_next = T1;
            end
            T1: begin
                // Held for every cycle spent waiting on memory.
                ZLowOut = 1'b1;
                PCin    = 1'b1;
                read    = 1'b1;
                MDRin   = 1'b1;
                if (mem_ready) state_next = T2;
            end
            T2: begin
                MDRout     = 1'b1;
                IRin       = 1'b1;
                state_next = T3;
            end
            T3: begin
                Yin        = 1'b1;
                Rout       = hilo ? reg_onehot(ra) : reg_onehot(rb);
                state_next = T4;
            end
            T4: begin
                Zin        = 1'b1;
                opcode     = op;
                Rout       = hilo ? reg_onehot(rb) : reg_onehot(rc);
                state_next = T5;
            end
            T5: begin
                ZLowOut = 1'b1;
                if (hilo) begin
                    LOin       = 1'b1;
                    state_next = T6;
                end else begin
                    Rin        = reg_onehot(ra);
                    state_next = IDLE;
                end
            end
            T6: begin
                ZHighOut   = 1'b1;
                HIin       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    // Strobe vector layout: {PCout,PCin,incPC,MARin,MDRin,MDRout,read,IRin,
    //                        Yin,Zin,ZLowOut,ZHighOut,LOin,HIin}
    localparam logic [13:0] S_PCOUT  = 14'h2000;
    localparam logic [13:0] S_PCIN   = 14'h1000;
    localparam logic [13:0] S_INCPC  = 14'h0800;
    localparam logic [13:0] S_MARIN  = 14'h0400;
    localparam logic [13:0] S_MDRIN  = 14'h0200;
    localparam logic [13:0] S_MDROUT = 14'h0100;
    localparam logic [13:0] S_READ   = 14'h0080;
    localparam logic [13:0] S_IRIN   = 14'h0040;
    localparam logic [13:0] S_YIN    = 14'h0020;
    localparam logic [13:0] S_ZIN    = 14'h0010;
    localparam logic [13:0] S_ZLOW   = 14'h0008;
    localparam logic [13:0] S_ZHIGH  = 14'h0004;
    localparam logic [13:0] S_LOIN   = 14'h0002;
    localparam logic [13:0] S_HIIN   = 14'h0001;

    localparam logic [2:0] ST_T0 = 3'd1, ST_T1 = 3'd2, ST_T2 = 3'd3, ST_T3 = 3'd4;
    localparam logic [2:0] ST_T4 = 3'd5, ST_T5 = 3'd6, ST_T6 = 3'd7;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic clear = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic        start = 1'b0;
    logic        start_b = 1'b0;
    logic        mem_ready = 1'b1;
    logic [31:0] ir = '0;

    // ---------------- DUT A (16 registers) ----------------
    logic [15:0] rin_a, rout_a;
    logic [4:0]  opcode_a;
    logic [2:0]  state_a;
    logic        busy_a, done_a;
    logic        pcout_a, pcin_a, incpc_a, marin_a, mdrin_a, mdrout_a, read_a, irin_a;
    logic        yin_a, zin_a, zlow_a, zhigh_a, loin_a, hiin_a;

    alu_op_sequencer dut_a (
        .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
        .Rin(rin_a), .Rout(rout_a),
        .PCout(pcout_a), .PCin(pcin_a), .incPC(incpc_a), .MARin(marin_a),
        .MDRin(mdrin_a), .MDRout(mdrout_a), .read(read_a), .IRin(irin_a),
        .Yin(yin_a), .Zin(zin_a), .ZLowOut(zlow_a), .ZHighOut(zhigh_a),
        .LOin(loin_a), .HIin(hiin_a),
        .opcode(opcode_a), .busy(busy_a), .done(done_a), .state_dbg(state_a)
    );

    // ---------------- DUT B (8 registers) ----------------
    logic [7:0]  rin_b, rout_b;
    logic [4:0]  opcode_b;
    logic [2:0]  state_b;
    logic        busy_b, done_b;
    logic        pcout_b, pcin_b, incpc_b, marin_b, mdrin_b, mdrout_b, read_b, irin_b;
    logic        yin_b, zin_b, zlow_b, zhigh_b, loin_b, hiin_b;

    alu_op_sequencer #(.NUM_REGS(8)) dut_b (
        .clock(clock), .clear(clear), .start(start_b), .mem_ready(mem_ready), .ir(ir),
        .Rin(rin_b), .Rout(rout_b),
        .PCout(pcout_b), .PCin(pcin_b), .incPC(incpc_b), .MARin(marin_b),
        .MDRin(mdrin_b), .MDRout(mdrout_b), .read(read_b), .IRin(irin_b),
        .Yin(yin_b), .Zin(zin_b), .ZLowOut(zlow_b), .ZHighOut(zhigh_b),
        .LOin(loin_b), .HIin(hiin_b),
        .opcode(opcode_b), .busy(busy_b), .done(done_b), .state_dbg(state_b)
    );

    // Observation vector: {state, Rin, Rout, strobes, opcode, busy, done}
    logic [55:0] obs_a, obs_b;
    assign obs_a = {state_a, rin_a, rout_a,
                    pcout_a, pcin_a, incpc_a, marin_a, mdrin_a, mdrout_a, read_a, irin_a,
                    yin_a, zin_a, zlow_a, zhigh_a, loin_a, hiin_a,
                    opcode_a, busy_a, done_a};
    assign obs_b = {state_b, 8'h00, rin_b, 8'h00, rout_b,
                    pcout_b, pcin_b, incpc_b, marin_b, mdrin_b, mdrout_b, read_b, irin_b,
                    yin_b, zin_b, zlow_b, zhigh_b, loin_b, hiin_b,
                    opcode_b, busy_b, done_b};

    // ---------------- scoreboard ----------------
    logic [55:0] exp_q_a[$];
    logic [55:0] exp_q_b[$];
    int          exp_cyc_a[$];
    int          exp_cyc_b[$];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [55:0] ob(input logic [2:0] st, input logic [15:0] rin,
                                       input logic [15:0] rout, input logic [13:0] s,
                                       input logic [4:0] op, input logic busy,
                                       input logic done);
        return {st, rin, rout, s, op, busy, done};
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'h0000};
    endfunction

    task automatic chk(input string name, input logic [55:0] act, input logic [55:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int which, input int c, input logic [55:0] v);
        if (which == 0) begin
            exp_q_a.push_back(v);
            exp_cyc_a.push_back(c);
        end else begin
            exp_q_b.push_back(v);
            exp_cyc_b.push_back(c);
        end
    endtask

    task automatic push_step(input int which, input int c, input logic [2:0] st,
                             input logic [13:0] s, input logic [15:0] rin,
                             input logic [15:0] rout, input logic [4:0] op);
        push(which, c, ob(st, rin, rout, s, op, 1'b1, 1'b0));
    endtask

    task automatic push_done(input int which, input int c);
        push(which, c, ob(3'd0, 16'h0, 16'h0, 14'h0, 5'h0, 1'b0, 1'b1));
    endtask

    // Fetch steps from T0 at cycle t0, with 'stall' extra T1 cycles.
    task automatic push_fetch(input int which, input int t0, input int stall);
        push_step(which, t0, ST_T0, S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 16'h0, 16'h0, 5'h0);
        for (int i = 0; i <= stall; i++)
            push_step(which, t0 + 1 + i, ST_T1, S_ZLOW | S_PCIN | S_READ | S_MDRIN,
                      16'h0, 16'h0, 5'h0);
        push_step(which, t0 + 2 + stall, ST_T2, S_MDROUT | S_IRIN, 16'h0, 16'h0, 5'h0);
    endtask

    // Monitor: any cycle with busy or done must match the head of the queue,
    // both in value and in cycle number; any other cycle must be all-zero.
    task automatic mon(input int which, input logic [55:0] act);
        logic [55:0] e;
        int          ec;
        int          n;
        n = (which == 0) ? exp_q_a.size() : exp_q_b.size();
        if (act[1] === 1'b1 || act[0] === 1'b1) begin
            checks++;
            if (n == 0) begin
                errors++;
                $display("FAIL unexpected_output dut%0d cyc %0d got %h expected idle", which, cyc, act);
            end else begin
                if (which == 0) begin e = exp_q_a.pop_front(); ec = exp_cyc_a.pop_front(); end
                else            begin e = exp_q_b.pop_front(); ec = exp_cyc_b.pop_front(); end
                if (act !== e || ec != cyc) begin
                    errors++;
                    $display("FAIL step dut%0d cyc %0d got %h expected %h at cyc %0d",
                             which, cyc, act, e, ec);
                end
            end
        end else begin
            checks++;
            if (n != 0) begin
                ec = (which == 0) ? exp_cyc_a[0] : exp_cyc_b[0];
                if (ec <= cyc) begin
                    if (which == 0) begin e = exp_q_a.pop_front(); ec = exp_cyc_a.pop_front(); end
                    else            begin e = exp_q_b.pop_front(); ec = exp_cyc_b.pop_front(); end
                    errors++;
                    $display("FAIL missing_step dut%0d cyc %0d got %h expected %h", which, cyc, act, e);
                    return;
                end
            end
            if (act !== 56'h0) begin
                errors++;
                $display("FAIL idle_outputs dut%0d cyc %0d got %h expected 0", which, cyc, act);
            end
        end
    endtask

    always @(negedge clock) begin
        mon(0, obs_a);
        mon(1, obs_b);
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Called at cycle n (just after an edge); T0 lands at n+1. The IR holds a
    // garbage value during fetch and the real instruction from T2 on.
    task automatic drive_instr(input int which, input logic [31:0] instr, input int stall);
        int n;
        n = cyc;
        if (which == 0) start = 1'b1; else start_b = 1'b1;
        ir        = ~instr;
        mem_ready = (stall == 0);
        wait_cyc(n + 1);
        start   = 1'b0;
        start_b = 1'b0;
        if (stall > 0) begin
            wait_cyc(n + 2 + stall);
            mem_ready = 1'b1;
        end
        wait_cyc(n + 3 + stall);
        ir = instr;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        int t1;

        #2;
        chk("reset_a", obs_a, 56'h0);
        chk("reset_b", obs_b, 56'h0);
        wait_cyc(2);
        clear = 1'b0;
        wait_cyc(4);

        // Regular SUB R7 = R4 - R3
        t0 = cyc + 1;
        push_fetch(0, t0, 0);
        push_step(0, t0 + 3, ST_T3, S_YIN, 16'h0, 16'h0010, 5'h0);
        push_step(0, t0 + 4, ST_T4, S_ZIN, 16'h0, 16'h0008, 5'b00100);
        push_step(0, t0 + 5, ST_T5, S_ZLOW, 16'h0080, 16'h0, 5'h0);
        push_done(0, t0 + 6);
        drive_instr(0, mk_ir(5'b00100, 4'd7, 4'd4, 4'd3), 0);
        wait_cyc(t0 + 9);

        // MUL ra=2 rb=5, with a start pulse during T3 that must be ignored
        t0 = cyc + 1;
        push_fetch(0, t0, 0);
        push_step(0, t0 + 3, ST_T3, S_YIN, 16'h0, 16'h0004, 5'h0);
        push_step(0, t0 + 4, ST_T4, S_ZIN, 16'h0, 16'h0020, 5'b01111);
        push_step(0, t0 + 5, ST_T5, S_ZLOW | S_LOIN, 16'h0, 16'h0, 5'h0);
        push_step(0, t0 + 6, ST_T6, S_ZHIGH | S_HIIN, 16'h0, 16'h0, 5'h0);
        push_done(0, t0 + 7);
        drive_instr(0, mk_ir(5'b01111, 4'd2, 4'd5, 4'd0), 0);
        wait_cyc(t0 + 3);
        start = 1'b1;
        wait_cyc(t0 + 4);
        start = 1'b0;
        wait_cyc(t0 + 11);

        // SUB again with a 3-cycle memory stall: done 3 cycles later
        t0 = cyc + 1;
        push_fetch(0, t0, 3);
        push_step(0, t0 + 6, ST_T3, S_YIN, 16'h0, 16'h0010, 5'h0);
        push_step(0, t0 + 7, ST_T4, S_ZIN, 16'h0, 16'h0008, 5'b00100);
        push_step(0, t0 + 8, ST_T5, S_ZLOW, 16'h0080, 16'h0, 5'h0);
        push_done(0, t0 + 9);
        drive_instr(0, mk_ir(5'b00100, 4'd7, 4'd4, 4'd3), 3);
        wait_cyc(t0 + 12);

        // Reset asserted during T4 clears everything before the next edge
        t0 = cyc + 1;
        push_fetch(0, t0, 0);
        push_step(0, t0 + 3, ST_T3, S_YIN, 16'h0, 16'h0010, 5'h0);
        drive_instr(0, mk_ir(5'b00100, 4'd7, 4'd4, 4'd3), 0);
        wait_cyc(t0 + 4);
        clear = 1'b1;
        #1;
        chk("reset_mid_op", obs_a, 56'h0);
        wait_cyc(t0 + 5);
        clear = 1'b0;
        #1;
        chk("after_reset_release", obs_a, 56'h0);
        wait_cyc(t0 + 8);

        // Back-to-back with start held: ADD then DIV, no gap cycle
        t0 = cyc + 1;
        t1 = t0 + 7;
        push_fetch(0, t0, 0);
        push_step(0, t0 + 3, ST_T3, S_YIN, 16'h0, 16'h0004, 5'h0);
        push_step(0, t0 + 4, ST_T4, S_ZIN, 16'h0, 16'h8000, 5'b00011);
        push_step(0, t0 + 5, ST_T5, S_ZLOW, 16'h0002, 16'h0, 5'h0);
        push_done(0, t0 + 6);
        push_fetch(0, t1, 0);
        push_step(0, t1 + 3, ST_T3, S_YIN, 16'h0, 16'h0200, 5'h0);
        push_step(0, t1 + 4, ST_T4, S_ZIN, 16'h0, 16'h0400, 5'b10000);
        push_step(0, t1 + 5, ST_T5, S_ZLOW | S_LOIN, 16'h0, 16'h0, 5'h0);
        push_step(0, t1 + 6, ST_T6, S_ZHIGH | S_HIIN, 16'h0, 16'h0, 5'h0);
        push_done(0, t1 + 7);
        start     = 1'b1;
        mem_ready = 1'b1;
        ir        = mk_ir(5'b00011, 4'd1, 4'd2, 4'd15);
        wait_cyc(t0 + 6);
        ir = mk_ir(5'b10000, 4'd9, 4'd10, 4'd0);
        wait_cyc(t1);
        start = 1'b0;
        wait_cyc(t1 + 10);

        // 8-register instance, rc=12 out of range: T4 drives no register
        t0 = cyc + 1;
        push_fetch(1, t0, 0);
        push_step(1, t0 + 3, ST_T3, S_YIN, 16'h0, 16'h0002, 5'h0);
        push_step(1, t0 + 4, ST_T4, S_ZIN, 16'h0, 16'h0000, 5'b00010);
        push_step(1, t0 + 5, ST_T5, S_ZLOW, 16'h0040, 16'h0, 5'h0);
        push_done(1, t0 + 6);
        drive_instr(1, mk_ir(5'b00010, 4'd6, 4'd1, 4'd12), 0);
        wait_cyc(t0 + 10);

        checks++;
        if (exp_q_a.size() != 0 || exp_q_b.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d/%0d pending expected 0/0",
                     exp_q_a.size(), exp_q_b.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Hardwired control-step sequencer that generates the datapath control strobes for one register-register ALU instruction: fetch (T0–T2) followed by execute (T3–T5, plus T6 for MUL/DIV). It replaces the hand-timed control waveforms driven into `datapath` during bring-up. It sits between the instruction register output and the datapath's enable/select inputs. It is parametrised in register count, IR field layout and MUL/DIV opcodes, and it adds a memory wait handshake and a two-step HI/LO writeback.

## Interface
- `NUM_REGS`, 16: number of general registers; width of the one-hot `Rin`/`Rout` vectors (2..16).
- `IR_W`, 32: instruction register width.
- `OP_W`, 5: opcode field width. The field is IR[IR_W-1 -: OP_W].
- `RIDX_W`, 4: register-index field width. Ra, Rb and Rc follow the opcode, MSB first.
- `MUL_OP`, 5'b01111: opcode taking the HI/LO path (multiply).
- `DIV_OP`, 5'b10000: opcode taking the HI/LO path (divide).

Ports:
- `clock`  in  1  system clock; all state changes on rising edge.
- `clear`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request to run one instruction; sampled only in IDLE.
- `mem_ready`  in  1  memory read data valid; sampled in T1.
- `ir`  in  IR_W  current IR contents from datapath.
- `Rin`  out  NUM_REGS  one-hot register load enables.
- `Rout`  out  NUM_REGS  one-hot register bus-drive enables.
- `PCout`, `PCin`, `incPC`, `MARin`, `MDRin`, `MDRout`, `read`, `IRin`, `Yin`, `Zin`, `ZLowOut`, `ZHighOut`, `LOin`, `HIin`  out  1 each  datapath strobes.
- `opcode`  out  OP_W  ALU operation select.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on instruction completion.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6. The state register is binary encoded. All outputs are Moore-decoded from the state, plus the `ir` fields in T3–T6. Every unlisted strobe is 0.
- IDLE: all strobes 0. If `start`=1, go to T0.
- T0: `PCout`, `MARin`, `incPC`, `Zin` = 1. Go to T1.
- T1: `ZLowOut`, `PCin`, `read`, `MDRin` = 1. These are held every cycle the block stays in T1. Go to T2 when `mem_ready`=1, otherwise stay in T1.
- T2: `MDRout`, `IRin` = 1. Go to T3.
- Decode from `ir`: op = opcode field; ra, rb, rc = index fields. HI/LO path applies when op == MUL_OP or op == DIV_OP.
- T3: `Yin` = 1. Regular op: `Rout[rb]` = 1. HI/LO path: `Rout[ra]` = 1. Go to T4.
- T4: `Zin` = 1 and `opcode` = op. Regular op: `Rout[rc]` = 1. HI/LO path: `Rout[rb]` = 1. Go to T5.
- T5: `ZLowOut` = 1. Regular op: `Rin[ra]` = 1, then go to IDLE. HI/LO path: `LOin` = 1, then go to T6.
- T6: `ZHighOut`, `HIin` = 1. Go to IDLE.
- `opcode` output is 0 outside T4.
- Out-of-range register index (value ≥ NUM_REGS): the corresponding `Rin`/`Rout` vector is all zeros for that step. Sequencing is unaffected.
- At most one bit of `Rin` is set in any cycle, and at most one bit of `Rout`. `Rin` and `Rout` are never both nonzero in the same cycle.
- `done`: registered flag, set on the edge leaving T5 (regular path) or T6 (HI/LO path). High for exactly the following cycle.
- `start` while `busy`=1 is ignored and not queued.

## Timing
- Reset: `clear`=1 forces IDLE immediately, without waiting for an edge. All outputs go to 0, including `busy`, `done`, `Rin`, `Rout` and `opcode`. This holds mid-instruction, including a T1 stall.
- Latency, `start` at edge k with `mem_ready` constantly 1:
  - Regular path: T0 at k+1, T5 at k+6, `done` high during cycle k+7.
  - HI/LO path: T6 at k+7, `done` high during cycle k+8.
- Each T1 cycle with `mem_ready`=0 adds exactly one cycle.
- Back-to-back: `start`=1 in the cycle where `done`=1 (IDLE) enters T0 on the next edge. This gives a throughput of 7 cycles per regular instruction.
- Changing `ir` outside T3–T6 has no effect on the outputs.

## Test plan
- Regular SUB: reset, R4=30, R3=25, `ir` = opcode 00100, ra=7, rb=4, rc=3; `start` pulse, `mem_ready`=1.
  - Strobes appear in the T0–T5 order above.
  - `Rout`=0x0010 in T3, `Rout`=0x0008 with `opcode`=00100 in T4, `Rin`=0x0080 in T5.
  - `done` in cycle k+7; datapath R7=5.
- MUL: `ir` op=01111, ra=2, rb=5.
  - T5 asserts `LOin`; T6 asserts `ZHighOut`+`HIin`.
  - `Rin` is 0 throughout; `done` in cycle k+8.
- Memory stall: `mem_ready` held 0 for 3 cycles in T1.
  - `read`/`MDRin`/`PCin` held high for 4 cycles.
  - `done` delayed by exactly 3 cycles versus the first test.
- Reset mid-op: assert `clear` during T4.
  - All outputs 0 before the next clock edge; state IDLE.
  - A later `start` runs a clean full sequence.
- `start` held high continuously: consecutive instructions run back-to-back, with `done` every 7 cycles. A `start` pulse during T3 is ignored.
- `NUM_REGS`=8 with rc=12: T4 drives `Rout`=0, `Zin`=1 and `opcode` as normal, and the sequence completes.
